led_loop: RTL and testbench
===========================

Name: led_loop

Overview:
- Drives a ring of NUM_LEDS indicator LEDs with a single lit LED that steps around the ring at a fixed rate.
- The `right` input selects the stepping direction.
- Forms the moving-target element of the target-practice game; LED_INDEX connects directly to the board LED pins.
- One prescaler generates the step tick; a position register holds the lit LED index.

Parameters:
- NUM_LEDS, 6, number of LEDs in the ring; fixed at 6 for this board; LED_INDEX width equals NUM_LEDS.
- STEP_CYCLES, 13500000, clk cycles per position step (0.5 s at 27 MHz); legal range >= 1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous active-high reset.
- right  input  1  direction select: 1 = step toward lower bit index, 0 = step toward higher bit index.
- LED_INDEX  output  6  one-hot LED drive; bit i lit means LED i on (polarity per Optional Feature).
- pos  output  3  binary index (0..5) of the lit LED.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - prescaler count = 0, pos = 0.
  - LED_INDEX = 6'b000001.
  - rst has priority over everything else.
- Prescaler:
  - Counter runs 0..STEP_CYCLES-1, incrementing every cycle while rst=0.
  - When count == STEP_CYCLES-1: the next edge returns count to 0 and asserts an internal one-cycle step.
  - Counter width is $clog2(STEP_CYCLES), minimum 1 bit.
  - STEP_CYCLES = 1 gives a step on every cycle.
- Step:
  - right=1: pos = (pos==0) ? NUM_LEDS-1 : pos-1.
  - right=0: pos = (pos==NUM_LEDS-1) ? 0 : pos+1.
  - right is sampled only on the step edge; changes between steps have no effect until the next step.
- Timing from reset release: first step takes effect on the STEP_CYCLES-th rising edge after the edge where rst is deasserted; subsequent steps follow every STEP_CYCLES cycles.
- Outputs:
  - LED_INDEX and pos are registered, with exactly one bit of LED_INDEX lit.
  - LED_INDEX = 1 << pos.
  - pos never leaves 0..NUM_LEDS-1.
- Wrap-around:
  - Bit 0 -> bit 5 when right=1.
  - Bit 5 -> bit 0 when right=0.
- Reset mid-period: count is discarded, pos returns to 0, and a full STEP_CYCLES period must elapse before the next step.
- right changing on the same edge as a step: the value present before that edge is used.
- X or undriven right before the first step: must not corrupt state; reset defines all registers.

Optional Feature:
- Macro: LED_LOOP_ACTIVE_LOW_EN.
- Defined: LED_INDEX is the bitwise inverse of the one-hot value (the lit LED drives 0). Reset value is 6'b111110. pos is unaffected.
- Undefined: LED_INDEX is active-high one-hot as described above.

Test Plan:
- Apply rst=1 for 2 cycles with STEP_CYCLES=4 -> LED_INDEX=6'b000001, pos=0; no change during cycles 1-3 after release.
- Release reset with right=1 -> after 4 cycles LED_INDEX=6'b100000 (pos=5, wrap); after 4 more cycles 6'b010000 (pos=4).
- Release reset with right=0 -> LED_INDEX steps 000001, 000010, 000100, 001000, 010000, 100000, then 000001 (wrap), every 4 cycles.
- Toggle right mid-period (right=0 at pos=2, switched to 1 two cycles before the step) -> next step goes to pos=1, LED_INDEX=6'b000010.
- Assert rst for one cycle at count=2 with pos=3 -> LED_INDEX=6'b000001; the next step occurs exactly 4 cycles after release.
- Build with LED_LOOP_ACTIVE_LOW_EN -> reset LED_INDEX=6'b111110; after one right=1 step, 6'b011111.

Source files
------------

// File: rtl/led_loop.sv
// Single lit LED stepping around a ring of NUM_LEDS LEDs, one step every STEP_CYCLES clocks.
// Define LED_LOOP_ACTIVE_LOW_EN to drive LED_INDEX active-low (lit LED = 0).
module led_loop #(
    parameter int NUM_LEDS    = 6,
    parameter int STEP_CYCLES = 13500000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                right,
    output logic [NUM_LEDS-1:0] LED_INDEX,
    output logic [2:0]          pos
);

    localparam int                CW        = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0]     CNT_LAST  = CW'(STEP_CYCLES - 1);
    localparam logic [2:0]        POS_LAST  = 3'(NUM_LEDS - 1);
    localparam logic [NUM_LEDS-1:0] ONE_HOT0 = NUM_LEDS'(1);

    logic [CW-1:0]       count_r;
    logic                step_s;
    logic [2:0]          pos_next_s;
    logic [NUM_LEDS-1:0] led_next_s;

    // Prescaler: free-running modulo-STEP_CYCLES counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else if (step_s) begin
            count_r <= {CW{1'b0}};
        end else begin
            count_r <= count_r + CW'(1);
        end
    end

    // Step decode and next position with wrap in either direction.
    always_comb begin
        step_s     = (count_r == CNT_LAST);
        pos_next_s = pos;
        if (step_s) begin
            if (right) begin
                if (pos == 3'd0) begin
                    pos_next_s = POS_LAST;
                end else begin
                    pos_next_s = pos - 3'd1;
                end
            end else begin
                if (pos >= POS_LAST) begin
                    pos_next_s = 3'd0;
                end else begin
                    pos_next_s = pos + 3'd1;
                end
            end
        end else begin
            pos_next_s = pos;
        end
    end

    // LED drive derived from the next position so it lands together with pos.
    always_comb begin
`ifdef LED_LOOP_ACTIVE_LOW_EN
        led_next_s = ~(ONE_HOT0 << pos_next_s);
`else
        led_next_s = ONE_HOT0 << pos_next_s;
`endif
    end

    // Registered outputs; reset lights LED 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos <= 3'd0;
`ifdef LED_LOOP_ACTIVE_LOW_EN
            LED_INDEX <= ~ONE_HOT0;
`else
            LED_INDEX <= ONE_HOT0;
`endif
        end else begin
            pos       <= pos_next_s;
            LED_INDEX <= led_next_s;
        end
    end

endmodule

// File: tb/tb_led_loop.sv
// Self-checking bench for led_loop: directed sequence plus random direction/reset,
// compared against a modular-arithmetic model of the ring position.
module tb_led_loop;

    localparam int NL   = 6;
    localparam int STEP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          right;
    logic [NL-1:0] led4, led1;
    logic [2:0]    pos4, pos1;

    int checks = 0;
    int errors = 0;
    int m_pos  = 0;   // model position, STEP_CYCLES = 4
    int m_n    = 0;   // edges since reset release
    int m1_pos = 0;   // model position, STEP_CYCLES = 1

    led_loop #(.NUM_LEDS(NL), .STEP_CYCLES(STEP)) dut (
        .clk(clk), .rst(rst), .right(right), .LED_INDEX(led4), .pos(pos4)
    );

    led_loop #(.NUM_LEDS(NL), .STEP_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .right(right), .LED_INDEX(led1), .pos(pos1)
    );

    always #5 clk = ~clk;

    function automatic logic [NL-1:0] led_of(input int p);
        logic [NL-1:0] v;
        v = NL'(2 ** p);
`ifdef LED_LOOP_ACTIVE_LOW_EN
        v = ~v;
`endif
        return v;
    endfunction

    task automatic check_led(input string tag, input logic [NL-1:0] obs, input logic [NL-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_pos(input string tag, input logic [2:0] obs, input int exp);
        checks++;
        assert (obs === 3'(exp)) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: advance the model with the inputs present before the edge, then compare.
    task automatic tick();
        logic r_s, rst_s;
        r_s   = right;
        rst_s = rst;
        @(posedge clk);
        if (rst_s) begin
            m_pos  = 0;
            m_n    = 0;
            m1_pos = 0;
        end else begin
            m_n++;
            if (m_n % STEP == 0)
                m_pos = r_s ? (m_pos + NL - 1) % NL : (m_pos + 1) % NL;
            m1_pos = r_s ? (m1_pos + NL - 1) % NL : (m1_pos + 1) % NL;
        end
        #1;
        check_led("led4", led4, led_of(m_pos));
        check_pos("pos4", pos4, m_pos);
        if (!rst_s && r_s !== 1'bx) begin
            check_led("led1", led1, led_of(m1_pos));
            check_pos("pos1", pos1, m1_pos);
        end else if (rst_s) begin
            check_pos("pos1_rst", pos1, 0);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset for two cycles.
        rst = 1'b1; right = 1'b0;
        ticks(2);
        check_led("rst_led", led4, led_of(0));
        check_pos("rst_pos", pos4, 0);

        // right=1: wrap 0 -> 5, then 5 -> 4.
        rst = 1'b0; right = 1'b1;
        ticks(3);
        check_pos("hold_pos", pos4, 0);
        tick();
        check_pos("wrap_r_pos", pos4, 5);
        check_led("wrap_r_led", led4, led_of(5));
        ticks(4);
        check_pos("step_r_pos", pos4, 4);
        check_led("step_r_led", led4, led_of(4));

        // right=0: full lap with wrap 5 -> 0.
        rst = 1'b1; tick();
        rst = 1'b0; right = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            ticks(STEP);
            check_pos("fwd_pos", pos4, k % NL);
            check_led("fwd_led", led4, led_of(k % NL));
        end

        // Toggle direction mid-period at pos 2.
        ticks(STEP);
        check_pos("pre_toggle", pos4, 2);
        ticks(2);
        right = 1'b1;
        ticks(2);
        check_pos("toggle_pos", pos4, 1);
        check_led("toggle_led", led4, led_of(1));

        // Reset mid-period at count 2, pos 3.
        right = 1'b0;
        ticks(2 * STEP + 2);
        check_pos("pre_midrst", pos4, 3);
        rst = 1'b1; tick();
        check_led("midrst_led", led4, led_of(0));
        rst = 1'b0;
        ticks(STEP - 1);
        check_pos("midrst_hold", pos4, 0);
        tick();
        check_pos("midrst_step", pos4, 1);

        // Undriven direction before the first step.
        rst = 1'b1; right = 1'bx; tick();
        rst = 1'b0; ticks(2);
        check_pos("x_right_pos", pos4, 0);
        right = 1'b1; ticks(2);
        check_pos("x_right_step", pos4, 5);

        // Random direction and occasional reset.
        for (int i = 0; i < 400; i++) begin
            right = 1'($urandom_range(0, 1));
            rst   = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
